// File: rtl/ib_pkg.sv
// Shared types for the instruction-buffer dispatch slice: the buffered entry
// layout and the register-hazard helper used by the pair check.
package ib_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic        rd_we;
        logic        solo;
    } ib_entry_t;

    localparam int unsigned IB_ENTRY_W = $bits(ib_entry_t);
    localparam logic [4:0]  REG_ZERO   = 5'd0;

    // The zero register is hardwired, so writing it never creates a dependency.
    function automatic logic raw_hazard(input ib_entry_t older, input ib_entry_t younger);
        return older.rd_we && (older.rd != REG_ZERO) &&
               ((older.rd == younger.rj) || (older.rd == younger.rk));
    endfunction

endpackage

// File: rtl/ib_pair_check.sv
// Combinational dual-issue legality check for the two oldest buffered entries.
// Also intended for reuse by the rename stage.
module ib_pair_check
    import ib_pkg::*;
(
    input  ib_entry_t  entry0_i,
    input  ib_entry_t  entry1_i,
    input  logic [1:0] head_valid_i,
    output logic       pair_ok_o
);

    // Solo covers serialising ops in either slot and branches in slot 1;
    // the predecoder folds all of those into the single solo bit.
    assign pair_ok_o = (&head_valid_i) &&
                       !entry0_i.solo && !entry1_i.solo &&
                       !raw_hazard(entry0_i, entry1_i);

    logic unused_fields;
    assign unused_fields = ^{entry0_i.pc, entry0_i.inst, entry0_i.rj, entry0_i.rk,
                             entry1_i.pc, entry1_i.inst, entry1_i.rd, entry1_i.rd_we};

endmodule

// File: rtl/ib_dispatch.sv
// Dual-issue dispatch stage behind the instruction-buffer FIFO.
// Optional performance counters: define IB_DISPATCH_PERF_CNT_EN.
module ib_dispatch
    import ib_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 81,
    parameter bit          PAIR_EN    = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic [1:0]                head_valid,
    input  logic [1:0][DATA_WIDTH-1:0] fifo_data,
    output logic [1:0]                dqueue_en,
    output logic [1:0]                invalid_en,
    output logic [1:0]                issue_valid,
    output logic [1:0][DATA_WIDTH-1:0] issue_data,
    input  logic                      issue_ready,
    output logic [31:0]               perf_dual,
    output logic [31:0]               perf_single,
    output logic [31:0]               perf_stall
);

    ib_entry_t entry0, entry1;
    logic      pair_ok;
    logic      can_accept;
    logic      iss0, iss1;
    logic [1:0] pop;

    logic [1:0]                 issue_valid_q, issue_valid_d;
    logic [1:0][DATA_WIDTH-1:0] issue_data_q,  issue_data_d;

    assign entry0 = ib_entry_t'(fifo_data[0]);
    assign entry1 = ib_entry_t'(fifo_data[1]);

    ib_pair_check u_pair_check (
        .entry0_i     (entry0),
        .entry1_i     (entry1),
        .head_valid_i (head_valid),
        .pair_ok_o    (pair_ok)
    );

    assign can_accept = !(|issue_valid_q) || issue_ready;
    assign iss0       = can_accept && head_valid[0] && !flush;
    assign iss1       = iss0 && PAIR_EN && pair_ok;

    // FIFO strobes are forced low while reset is asserted so no pop escapes.
    assign pop        = reset_n ? {iss1, iss0} : 2'b00;
    assign invalid_en = pop;
    assign dqueue_en  = reset_n ? head_valid : 2'b00;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        if (flush) begin
            issue_valid_d = '0;
        end else if (can_accept) begin
            issue_valid_d = {iss1, iss0};
            issue_data_d  = fifo_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_q <= '0;
            issue_data_q  <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;

`ifdef IB_DISPATCH_PERF_CNT_EN
    logic [31:0] perf_dual_q,   perf_dual_d;
    logic [31:0] perf_single_q, perf_single_d;
    logic [31:0] perf_stall_q,  perf_stall_d;

    always_comb begin
        perf_dual_d   = perf_dual_q   + {31'd0, (pop == 2'b11)};
        perf_single_d = perf_single_q + {31'd0, (pop == 2'b01)};
        perf_stall_d  = perf_stall_q  + {31'd0, (head_valid[0] && (pop == 2'b00))};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            perf_dual_q   <= perf_dual_d;
            perf_single_q <= perf_single_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_dual   = perf_dual_q;
    assign perf_single = perf_single_q;
    assign perf_stall  = perf_stall_q;
`else
    assign perf_dual   = '0;
    assign perf_single = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_ib_dispatch.sv
// Directed, table-driven bench for ib_dispatch (dual-issue and PAIR_EN=0 builds).
module tb_ib_dispatch;
    import ib_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic [1:0]       head_valid;
    logic [1:0][80:0] fifo_data;
    logic             issue_ready;

    logic [1:0]       dqueue_en, invalid_en, issue_valid;
    logic [1:0][80:0] issue_data;
    logic [31:0]      perf_dual, perf_single, perf_stall;

    logic [1:0]       s_dqueue_en, s_invalid_en, s_issue_valid;
    logic [1:0][80:0] s_issue_data;
    logic [31:0]      s_perf_dual, s_perf_single, s_perf_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ib_dispatch #(.DATA_WIDTH(81), .PAIR_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .head_valid(head_valid),
        .fifo_data(fifo_data), .dqueue_en(dqueue_en), .invalid_en(invalid_en),
        .issue_valid(issue_valid), .issue_data(issue_data), .issue_ready(issue_ready),
        .perf_dual(perf_dual), .perf_single(perf_single), .perf_stall(perf_stall)
    );

    ib_dispatch #(.DATA_WIDTH(81), .PAIR_EN(1'b0)) dut_single (
        .clk(clk), .reset_n(reset_n), .flush(flush), .head_valid(head_valid),
        .fifo_data(fifo_data), .dqueue_en(s_dqueue_en), .invalid_en(s_invalid_en),
        .issue_valid(s_issue_valid), .issue_data(s_issue_data), .issue_ready(issue_ready),
        .perf_dual(s_perf_dual), .perf_single(s_perf_single), .perf_stall(s_perf_stall)
    );

    function automatic ib_entry_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [4:0] rj, input logic [4:0] rk,
                                     input logic we, input logic solo);
        ib_entry_t e;
        e.pc    = pc;
        e.inst  = pc ^ 32'h0bad_0013;
        e.rd    = rd;
        e.rj    = rj;
        e.rk    = rk;
        e.rd_we = we;
        e.solo  = solo;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [80:0] act, input logic [80:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] hv, input ib_entry_t e0, input ib_entry_t e1,
                         input logic rdy, input logic fl);
        head_valid   = hv;
        fifo_data[0] = e0;
        fifo_data[1] = e1;
        issue_ready  = rdy;
        flush        = fl;
    endtask

    task automatic drain();
        apply(2'b00, '0, '0, 1'b1, 1'b0);
        step();
    endtask

    typedef struct {
        string      name;
        logic [1:0] hv;
        ib_entry_t  e0;
        ib_entry_t  e1;
        logic       rdy;
        logic       fl;
        logic [1:0] exp_pop;
        logic [1:0] exp_iv;
    } vec_t;

    vec_t vecs[12];

    ib_entry_t a0, a1, p0, p1;

    initial begin
        vecs[0]  = '{"indep",   2'b11, mk(32'h100, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h104, 5'd8, 5'd6, 5'd7, 1, 0), 1, 0, 2'b11, 2'b11};
        vecs[1]  = '{"raw_rj",  2'b11, mk(32'h200, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h204, 5'd8, 5'd5, 5'd7, 1, 0), 1, 0, 2'b01, 2'b01};
        vecs[2]  = '{"raw_rk",  2'b11, mk(32'h300, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h304, 5'd8, 5'd6, 5'd5, 1, 0), 1, 0, 2'b01, 2'b01};
        vecs[3]  = '{"rd_zero", 2'b11, mk(32'h400, 5'd0, 5'd1, 5'd2, 1, 0), mk(32'h404, 5'd8, 5'd0, 5'd0, 1, 0), 1, 0, 2'b11, 2'b11};
        vecs[4]  = '{"no_we",   2'b11, mk(32'h500, 5'd5, 5'd1, 5'd2, 0, 0), mk(32'h504, 5'd8, 5'd5, 5'd5, 1, 0), 1, 0, 2'b11, 2'b11};
        vecs[5]  = '{"solo0",   2'b11, mk(32'h600, 5'd5, 5'd1, 5'd2, 1, 1), mk(32'h604, 5'd8, 5'd6, 5'd7, 1, 0), 1, 0, 2'b01, 2'b01};
        vecs[6]  = '{"solo1",   2'b11, mk(32'h700, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h704, 5'd8, 5'd6, 5'd7, 1, 1), 1, 0, 2'b01, 2'b01};
        vecs[7]  = '{"only_h0", 2'b01, mk(32'h800, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h804, 5'd8, 5'd6, 5'd7, 1, 0), 1, 0, 2'b01, 2'b01};
        vecs[8]  = '{"empty",   2'b00, mk(32'h900, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'h904, 5'd8, 5'd6, 5'd7, 1, 0), 1, 0, 2'b00, 2'b00};
        vecs[9]  = '{"flush",   2'b11, mk(32'ha00, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'ha04, 5'd8, 5'd6, 5'd7, 1, 0), 1, 1, 2'b00, 2'b00};
        vecs[10] = '{"waw",     2'b11, mk(32'hb00, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'hb04, 5'd5, 5'd1, 5'd2, 1, 0), 1, 0, 2'b11, 2'b11};
        vecs[11] = '{"only_h1", 2'b10, mk(32'hc00, 5'd5, 5'd1, 5'd2, 1, 0), mk(32'hc04, 5'd8, 5'd6, 5'd7, 1, 0), 1, 0, 2'b00, 2'b00};

        // Reset with a full head presented: strobes must stay low.
        reset_n = 1'b0;
        apply(2'b11, vecs[0].e0, vecs[0].e1, 1'b1, 1'b0);
        step();
        step();
        chk("rst_issue_valid", {79'd0, issue_valid}, '0);
        chk("rst_issue_data0", issue_data[0], '0);
        chk("rst_issue_data1", issue_data[1], '0);
        chk("rst_dqueue_en",   {79'd0, dqueue_en},  '0);
        chk("rst_invalid_en",  {79'd0, invalid_en}, '0);
        chk("rst_perf_dual",   {49'd0, perf_dual},   '0);
        chk("rst_perf_single", {49'd0, perf_single}, '0);
        chk("rst_perf_stall",  {49'd0, perf_stall},  '0);
        reset_n = 1'b1;
        drain();

        for (int unsigned i = 0; i < 12; i++) begin
            drain();
            apply(vecs[i].hv, vecs[i].e0, vecs[i].e1, vecs[i].rdy, vecs[i].fl);
            #1;
            chk({vecs[i].name, "_dqueue_en"},  {79'd0, dqueue_en},  {79'd0, vecs[i].hv});
            chk({vecs[i].name, "_invalid_en"}, {79'd0, invalid_en}, {79'd0, vecs[i].exp_pop});
            chk({vecs[i].name, "_nopair_invalid_en"}, {79'd0, s_invalid_en},
                {79'd0, vecs[i].exp_pop & 2'b01});
            step();
            chk({vecs[i].name, "_issue_valid"}, {79'd0, issue_valid}, {79'd0, vecs[i].exp_iv});
            chk({vecs[i].name, "_nopair_issue_valid"}, {79'd0, s_issue_valid},
                {79'd0, vecs[i].exp_iv & 2'b01});
            if (vecs[i].exp_iv[0]) chk({vecs[i].name, "_issue_data0"}, issue_data[0], vecs[i].e0);
            if (vecs[i].exp_iv[1]) chk({vecs[i].name, "_issue_data1"}, issue_data[1], vecs[i].e1);
        end

        // RAW split: held-back entry becomes slot 0 next cycle.
        drain();
        a0 = mk(32'h1000, 5'd5, 5'd1, 5'd2, 1, 0);
        a1 = mk(32'h1004, 5'd9, 5'd5, 5'd3, 1, 0);
        apply(2'b11, a0, a1, 1'b1, 1'b0);
        #1;
        chk("split_pop0", {79'd0, invalid_en}, {79'd0, 2'b01});
        step();
        chk("split_iv0",    {79'd0, issue_valid}, {79'd0, 2'b01});
        chk("split_data0",  issue_data[0], a0);
        apply(2'b01, a1, '0, 1'b1, 1'b0);
        #1;
        chk("split_pop1", {79'd0, invalid_en}, {79'd0, 2'b01});
        step();
        chk("split_iv1",    {79'd0, issue_valid}, {79'd0, 2'b01});
        chk("split_data1",  issue_data[0], a1);

        // Backpressure: pair held three cycles, then next pair pops on ready.
        drain();
        a0 = mk(32'h2000, 5'd5, 5'd1, 5'd2, 1, 0);
        a1 = mk(32'h2004, 5'd8, 5'd6, 5'd7, 1, 0);
        p0 = mk(32'h2008, 5'd10, 5'd1, 5'd2, 1, 0);
        p1 = mk(32'h200c, 5'd11, 5'd3, 5'd4, 1, 0);
        apply(2'b11, a0, a1, 1'b1, 1'b0);
        step();
        for (int unsigned c = 0; c < 3; c++) begin
            apply(2'b11, p0, p1, 1'b0, 1'b0);
            #1;
            chk("bp_pop", {79'd0, invalid_en}, '0);
            step();
            chk("bp_iv",    {79'd0, issue_valid}, {79'd0, 2'b11});
            chk("bp_data0", issue_data[0], a0);
            chk("bp_data1", issue_data[1], a1);
        end
        issue_ready = 1'b1;
        #1;
        chk("bp_release_pop", {79'd0, invalid_en}, {79'd0, 2'b11});
        step();
        chk("bp_release_data0", issue_data[0], p0);
        chk("bp_release_data1", issue_data[1], p1);

        // Flush while downstream stalled clears the register.
        apply(2'b11, a0, a1, 1'b0, 1'b1);
        #1;
        chk("flush_stall_pop", {79'd0, invalid_en}, '0);
        step();
        chk("flush_stall_iv", {79'd0, issue_valid}, '0);

        // Asynchronous reset in the middle of a transfer.
        apply(2'b11, a0, a1, 1'b1, 1'b0);
        step();
        chk("pre_areset_iv", {79'd0, issue_valid}, {79'd0, 2'b11});
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_iv",      {79'd0, issue_valid}, '0);
        chk("areset_data0",   issue_data[0], '0);
        chk("areset_pop",     {79'd0, invalid_en}, '0);
        chk("areset_dqueue",  {79'd0, dqueue_en}, '0);
        step();
        reset_n = 1'b1;
        drain();

        // Performance counters over alternating dual / RAW-split traffic.
        for (int unsigned c = 0; c < 10; c++) begin
            if (c % 2 == 0)
                apply(2'b11, mk(32'h3000 + c*8, 5'd5, 5'd1, 5'd2, 1, 0),
                             mk(32'h3004 + c*8, 5'd8, 5'd6, 5'd7, 1, 0), 1'b1, 1'b0);
            else
                apply(2'b11, mk(32'h3000 + c*8, 5'd5, 5'd1, 5'd2, 1, 0),
                             mk(32'h3004 + c*8, 5'd8, 5'd5, 5'd7, 1, 0), 1'b1, 1'b0);
            step();
        end
        issue_ready = 1'b0;
        step();
        step();
        apply(2'b00, '0, '0, 1'b0, 1'b0);
        #1;
`ifdef IB_DISPATCH_PERF_CNT_EN
        chk("perf_dual",   {49'd0, perf_dual},   81'd5);
        chk("perf_single", {49'd0, perf_single}, 81'd5);
        chk("perf_stall",  {49'd0, perf_stall},  81'd2);
`else
        chk("perf_dual_off",   {49'd0, perf_dual},   '0);
        chk("perf_single_off", {49'd0, perf_single}, '0);
        chk("perf_stall_off",  {49'd0, perf_stall},  '0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
